// File: rtl/sm_datapath_if.sv
// Controller <-> datapath bundle for the shift-add multiplier.
// The controller drives the operand/strobe side; the datapath returns MR, RS and the product stage.
interface sm_datapath_if #(
  parameter int N = 4
);
  logic [N-1:0]   md_in;
  logic [N-1:0]   mr_in;
  logic           mdld;
  logic           mrld;
  logic           rsload;
  logic           rsclear;
  logic           rsshr;
  logic [N-1:0]   mr;
  logic [2*N-1:0] rs;
  logic [2*N-1:0] prod_data;
  logic           prod_valid;
  logic           prod_ready;
  logic           overrun;
  logic           proto_err;

  modport master (
    output md_in, mr_in, mdld, mrld, rsload, rsclear, rsshr, prod_ready,
    input  mr, rs, prod_data, prod_valid, overrun, proto_err
  );

  modport slave (
    input  md_in, mr_in, mdld, mrld, rsload, rsclear, rsshr, prod_ready,
    output mr, rs, prod_data, prod_valid, overrun, proto_err
  );
endinterface

// File: rtl/sm_datapath.sv
// Shift-add multiplier datapath: MD/MR/RS registers, shift counter and a
// valid/ready capture stage for the finished 2N-bit product.
module sm_datapath #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst,
  sm_datapath_if.slave  bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [N-1:0]   md_q, md_d;
  logic [N-1:0]   mr_q, mr_d;
  logic [2*N-1:0] rs_q, rs_d;
  logic           c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] prod_data_q, prod_data_d;
  logic           prod_valid_q, prod_valid_d;
  logic           overrun_q, overrun_d;
  logic           proto_err_q, proto_err_d;

  logic [N:0]     sum;
  logic [2*N-1:0] shifted;
  logic [1:0]     op_cnt;
  logic           capture;
  logic           transfer;

  always_comb begin
    md_d         = md_q;
    mr_d         = mr_q;
    rs_d         = rs_q;
    c_d          = c_q;
    cnt_d        = cnt_q;
    prod_data_d  = prod_data_q;
    prod_valid_d = prod_valid_q;
    overrun_d    = overrun_q;
    proto_err_d  = proto_err_q;
    capture      = 1'b0;

    sum      = {1'b0, rs_q[2*N-1:N]} + {1'b0, md_q};
    shifted  = {c_q, rs_q[2*N-1:1]};
    op_cnt   = 2'(bus.rsclear) + 2'(bus.rsload) + 2'(bus.rsshr);
    transfer = prod_valid_q & bus.prod_ready;

    if (bus.mdld) md_d = bus.md_in;
    if (bus.mrld) mr_d = bus.mr_in;
    if (op_cnt > 2'd1) proto_err_d = 1'b1;

    // Only the highest-priority RS operation executes; the adder always sees the old MD.
    if (bus.rsclear) begin
      rs_d  = '0;
      c_d   = 1'b0;
      cnt_d = '0;
    end else if (bus.rsload) begin
      rs_d[2*N-1:N] = sum[N-1:0];
      c_d           = sum[N];
    end else if (bus.rsshr) begin
      rs_d = shifted;
      c_d  = 1'b0;
      if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
      capture = (cnt_q == CNT_LAST);
    end

    if (capture) begin
      prod_data_d  = shifted;
      prod_valid_d = 1'b1;
      if (prod_valid_q && !bus.prod_ready) overrun_d = 1'b1;
    end else if (transfer) begin
      prod_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_q         <= '0;
      mr_q         <= '0;
      rs_q         <= '0;
      c_q          <= 1'b0;
      cnt_q        <= '0;
      prod_data_q  <= '0;
      prod_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      md_q         <= md_d;
      mr_q         <= mr_d;
      rs_q         <= rs_d;
      c_q          <= c_d;
      cnt_q        <= cnt_d;
      prod_data_q  <= prod_data_d;
      prod_valid_q <= prod_valid_d;
      overrun_q    <= overrun_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign bus.mr         = mr_q;
  assign bus.rs         = rs_q;
  assign bus.prod_data  = prod_data_q;
  assign bus.prod_valid = prod_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.proto_err  = proto_err_q;
endmodule
